// File: rtl/excess3_to_bcd_deser_if.sv
// Digit-in / word-out handshake bundle for the excess-3 receive path.
interface excess3_to_bcd_deser_if #(
  parameter int DIGITS = 4
);
  logic [3:0]          x3_in;
  logic                in_valid;
  logic                in_ready;
  logic                flush;
  logic [4*DIGITS-1:0] bcd_out;
  logic                out_valid;
  logic                out_ready;
  logic                err;

  modport master (
    output x3_in, in_valid, flush, out_ready,
    input  in_ready, bcd_out, out_valid, err
  );

  modport slave (
    input  x3_in, in_valid, flush, out_ready,
    output in_ready, bcd_out, out_valid, err
  );
endinterface

// File: rtl/excess3_to_bcd_deser.sv
// Excess-3 digit deserializer: converts each digit to BCD (invalid -> 4'hF),
// packs DIGITS digits MS-first and holds the word until the consumer takes it.
module excess3_to_bcd_deser #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  excess3_to_bcd_deser_if.slave bus
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count_p0;
  logic [W-1:0]     word_p0;
  logic             err_p0;
  logic             armed;
  logic             in_ready_c;
  logic             out_valid_c;
  logic             accept;
  logic             last_digit;

  function automatic logic is_bad(input logic [3:0] code);
    return (code < 4'd3) || (code > 4'd12);
  endfunction

  function automatic logic [3:0] to_bcd(input logic [3:0] code);
    return is_bad(code) ? 4'hF : (code - 4'd3);
  endfunction

  assign accept     = bus.in_valid && in_ready_c;
  assign last_digit = (count_p0 == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (accept && last_digit) state_nxt = HOLD;
      HOLD:    if (bus.out_ready)        state_nxt = COLLECT;
      default:                           state_nxt = COLLECT;
    endcase
    if (bus.flush) state_nxt = COLLECT;
  end

  // armed keeps in_ready low until the first edge after reset release
  always_comb begin
    in_ready_c    = 1'b0;
    out_valid_c   = 1'b0;
    in_ready_c    = armed && (state == COLLECT);
    out_valid_c   = (state == HOLD);
    bus.in_ready  = in_ready_c;
    bus.out_valid = out_valid_c;
    bus.err       = out_valid_c && err_p0;
    bus.bcd_out   = word_p0;
  end

  // stage p0: digit accept, shift-in and sticky word error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed    <= 1'b0;
      count_p0 <= '0;
      word_p0  <= '0;
      err_p0   <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (bus.flush) begin
        count_p0 <= '0;
        err_p0   <= 1'b0;
      end else if (accept) begin
        word_p0  <= (word_p0 << 4) | W'(to_bcd(bus.x3_in));
        err_p0   <= err_p0 | is_bad(bus.x3_in);
        count_p0 <= last_digit ? '0 : count_p0 + CNT_W'(1);
      end else if ((state == HOLD) && bus.out_ready) begin
        err_p0 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_excess3_to_bcd_deser.sv
// Bench for excess3_to_bcd_deser: directed scenarios plus a randomized run
// against a word-level queue model.
module tb_excess3_to_bcd_deser;

  localparam int DIGITS = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  excess3_to_bcd_deser_if #(.DIGITS(DIGITS)) bus ();

  excess3_to_bcd_deser #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_nib(input logic [3:0] c);
    return (c >= 4'd3 && c <= 4'd12) ? (c - 4'd3) : 4'hF;
  endfunction

  // Called at a negedge in COLLECT; returns at the negedge after the last accept.
  task automatic send_word(input logic [15:0] codes);
    for (int i = 0; i < 4; i++) begin
      chk("in_ready_collect", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.x3_in    = codes[15-4*i -: 4];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [15:0] w, input logic e);
    chk({tag, "_ovld"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_bcd"},  32'(bus.bcd_out),   32'(w));
    chk({tag, "_err"},  32'(bus.err),       32'(e));
    chk({tag, "_irdy"}, 32'(bus.in_ready),  32'd0);
  endtask

  task automatic expect_consumed(input string tag);
    @(negedge clk);
    chk({tag, "_ovld_lo"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_err_lo"},  32'(bus.err),       32'd0);
    chk({tag, "_irdy_hi"}, 32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    logic [3:0]  stream [12];
    logic [15:0] sexp [3];
    logic [3:0]  q [$];
    logic        pend, pe, iv, orr, fl;
    logic [15:0] pw;
    logic [3:0]  code;
    int idx, w, last_cyc;

    rst = 1'b1;
    bus.x3_in = 4'h0; bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    chk("rst_irdy", 32'(bus.in_ready),  32'd0);
    chk("rst_ovld", 32'(bus.out_valid), 32'd0);
    chk("rst_err",  32'(bus.err),       32'd0);
    chk("rst_bcd",  32'(bus.bcd_out),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_irdy", 32'(bus.in_ready), 32'd1);

    // basic word
    bus.out_ready = 1'b1;
    send_word(16'h47AC);
    expect_word("basic", 16'h1479, 1'b0);
    expect_consumed("basic");

    // invalid code, then clean word
    send_word(16'h4256);
    expect_word("inval", 16'h1F23, 1'b1);
    expect_consumed("inval");
    send_word(16'h3333);
    expect_word("clean", 16'h0000, 1'b0);
    expect_consumed("clean");

    // backpressure with a source holding in_valid high
    bus.out_ready = 1'b0;
    send_word(16'h4067);
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.x3_in    = 4'h8;
      expect_word("bp_hold", 16'h1F34, 1'b1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ovld_lo", 32'(bus.out_valid), 32'd0);
    send_word(16'h89AB);
    expect_word("bp_next", 16'h5678, 1'b0);
    expect_consumed("bp_next");

    // flush mid-word with a simultaneous digit
    bus.in_valid = 1'b1; bus.x3_in = 4'h5;
    @(negedge clk);
    bus.x3_in = 4'h6;
    @(negedge clk);
    bus.flush = 1'b1; bus.x3_in = 4'h9;
    @(negedge clk);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_ovld", 32'(bus.out_valid), 32'd0);
    send_word(16'h3456);
    expect_word("flush_word", 16'h0123, 1'b0);
    expect_consumed("flush_word");

    // flush while holding an errored word
    bus.out_ready = 1'b0;
    send_word(16'h4F44);
    expect_word("hflush_pre", 16'h1F11, 1'b1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("hflush_ovld", 32'(bus.out_valid), 32'd0);
    chk("hflush_err",  32'(bus.err),       32'd0);
    chk("hflush_irdy", 32'(bus.in_ready),  32'd1);
    send_word(16'h5555);
    expect_word("hflush_next", 16'h2222, 1'b0);

    // async reset during HOLD
    bus.out_ready = 1'b1;
    expect_consumed("pre_arst");
    bus.out_ready = 1'b0;
    send_word(16'h7809);
    expect_word("arst_pre", 16'h45F6, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ovld", 32'(bus.out_valid), 32'd0);
    chk("arst_err",  32'(bus.err),       32'd0);
    chk("arst_bcd",  32'(bus.bcd_out),   32'd0);
    chk("arst_irdy", 32'(bus.in_ready),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    send_word(16'hCCCC);
    expect_word("arst_word", 16'h9999, 1'b0);
    expect_consumed("arst_word");

    // streaming: three words back-to-back
    stream = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'h3, 4'h4};
    sexp   = '{16'h0123, 16'h4567, 16'h8901};
    idx = 0; w = 0; last_cyc = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.out_valid) begin
        if (w < 3) begin
          chk("stream_bcd", 32'(bus.bcd_out), 32'(sexp[w]));
          chk("stream_err", 32'(bus.err), 32'd0);
          if (w > 0) chk("stream_period", 32'(c - last_cyc), 32'd5);
        end
        last_cyc = c;
        w++;
      end
      if (idx < 12) begin
        bus.in_valid = 1'b1;
        bus.x3_in    = stream[idx];
        if (bus.in_ready) idx++;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("stream_words", 32'(w), 32'd3);

    // randomized run against a word-level model
    bus.in_valid = 1'b0; bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    q.delete(); pend = 1'b0; pe = 1'b0; pw = 16'h0;
    for (int c = 0; c < 600; c++) begin
      chk("rnd_ovld", 32'(bus.out_valid), 32'(pend));
      chk("rnd_irdy", 32'(bus.in_ready),  32'(!pend));
      chk("rnd_err",  32'(bus.err),       32'(pend ? pe : 1'b0));
      if (pend) chk("rnd_bcd", 32'(bus.bcd_out), 32'(pw));
      iv   = ($urandom_range(0, 3) != 0);
      orr  = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      code = 4'($urandom_range(0, 15));
      bus.in_valid = iv; bus.out_ready = orr; bus.flush = fl; bus.x3_in = code;
      if (fl) begin
        q.delete();
        pend = 1'b0;
      end else if (pend) begin
        if (orr) pend = 1'b0;
      end else if (iv) begin
        q.push_back(code);
        if (q.size() == DIGITS) begin
          pw = 16'h0; pe = 1'b0;
          foreach (q[k]) begin
            pw = (pw << 4) | 16'(ref_nib(q[k]));
            pe = pe | (ref_nib(q[k]) == 4'hF);
          end
          pend = 1'b1;
          q.delete();
        end
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
